// File: rtl/sharpen_core_if.sv
// 3x3 window request/response bundle between the frame top level and sharpen_core.
// The initiator drives the window and enable; the responder returns the sharpened pixel.
interface sharpen_core_if #(
  parameter int unsigned CNT_W = 17
);
  logic             en_i;
  logic [7:0]       data_i_0;
  logic [7:0]       data_i_1;
  logic [7:0]       data_i_2;
  logic [7:0]       data_i_3;
  logic [7:0]       data_i_4;
  logic [7:0]       data_i_5;
  logic [7:0]       data_i_6;
  logic [7:0]       data_i_7;
  logic [7:0]       data_i_8;
  logic [7:0]       data_o;
  logic             sonuc_done;
  logic             sat_o;
  logic [CNT_W-1:0] done_cnt_o;

  modport master (
    output en_i, data_i_0, data_i_1, data_i_2, data_i_3, data_i_4,
           data_i_5, data_i_6, data_i_7, data_i_8,
    input  data_o, sonuc_done, sat_o, done_cnt_o
  );

  modport slave (
    input  en_i, data_i_0, data_i_1, data_i_2, data_i_3, data_i_4,
           data_i_5, data_i_6, data_i_7, data_i_8,
    output data_o, sonuc_done, sat_o, done_cnt_o
  );
endinterface

// File: rtl/sharpen_core.sv
// Laplacian sharpening of a 3x3 window centre pixel, saturated to 0..255.
// Three-cycle pipeline: capture, kernel sum, clamp; result held until the enable drops.
module sharpen_core #(
  parameter int unsigned KERNEL_SEL = 0,
  parameter int unsigned CNT_W      = 17
) (
  input logic           clk_i,
  input logic           rst_i,
  sharpen_core_if.slave win
);

  typedef enum logic [1:0] {StIdle, StAdd, StClamp, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         pix_q [9];
  logic [7:0]         pix_d [9];
  logic [7:0]         pix_in [9];
  logic signed [12:0] op [9];
  logic signed [12:0] sum_q, sum_d;
  logic signed [12:0] kernel_sum;
  logic [7:0]         data_q, data_d;
  logic               done_q, done_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign pix_in[0] = win.data_i_0;
  assign pix_in[1] = win.data_i_1;
  assign pix_in[2] = win.data_i_2;
  assign pix_in[3] = win.data_i_3;
  assign pix_in[4] = win.data_i_4;
  assign pix_in[5] = win.data_i_5;
  assign pix_in[6] = win.data_i_6;
  assign pix_in[7] = win.data_i_7;
  assign pix_in[8] = win.data_i_8;

  // Zero-extend to 13 bits so the worst case (9*255) cannot overflow.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      op[i] = signed'({5'b0_0000, pix_q[i]});
    end
  end

  always_comb begin
    if (KERNEL_SEL == 0) begin
      kernel_sum = 13'sd5 * op[4] - op[1] - op[3] - op[5] - op[7];
    end else begin
      kernel_sum = 13'sd9 * op[4]
                 - (op[0] + op[1] + op[2] + op[3] + op[5] + op[6] + op[7] + op[8]);
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    sum_d   = sum_q;
    data_d  = data_q;
    done_d  = done_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (win.en_i) begin
          pix_d   = pix_in;
          state_d = StAdd;
        end
      end
      StAdd: begin
        if (!win.en_i) begin
          state_d = StIdle;
        end else begin
          sum_d   = kernel_sum;
          state_d = StClamp;
        end
      end
      StClamp: begin
        if (!win.en_i) begin
          state_d = StIdle;
        end else begin
          if (sum_q < 13'sd0) begin
            data_d = 8'd0;
            sat_d  = 1'b1;
          end else if (sum_q > 13'sd255) begin
            data_d = 8'd255;
            sat_d  = 1'b1;
          end else begin
            data_d = sum_q[7:0];
            sat_d  = 1'b0;
          end
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StDone;
        end
      end
      StDone: begin
        // Stay here while the enable is held so one request yields one result.
        if (!win.en_i) begin
          done_d  = 1'b0;
          sat_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      for (int i = 0; i < 9; i++) begin
        pix_q[i] <= 8'd0;
      end
      sum_q  <= '0;
      data_q <= 8'd0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign win.data_o     = data_q;
  assign win.sonuc_done = done_q;
  assign win.sat_o      = sat_q;
  assign win.done_cnt_o = cnt_q;

endmodule

// File: tb/tb_sharpen_core.sv
// Directed bench for sharpen_core: both kernels side by side plus a narrow-counter
// instance, all driven by the same window stream.
module tb_sharpen_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] px [9];
  int         n_err = 0;
  int         n_chk = 0;
  int         exp_cnt = 0;

  always #5 clk = ~clk;

  sharpen_core_if #(.CNT_W(17)) w0 ();
  sharpen_core_if #(.CNT_W(17)) w1 ();
  sharpen_core_if #(.CNT_W(2))  w2 ();

  assign w0.en_i = en;
  assign w1.en_i = en;
  assign w2.en_i = en;
  assign w0.data_i_0 = px[0]; assign w1.data_i_0 = px[0]; assign w2.data_i_0 = px[0];
  assign w0.data_i_1 = px[1]; assign w1.data_i_1 = px[1]; assign w2.data_i_1 = px[1];
  assign w0.data_i_2 = px[2]; assign w1.data_i_2 = px[2]; assign w2.data_i_2 = px[2];
  assign w0.data_i_3 = px[3]; assign w1.data_i_3 = px[3]; assign w2.data_i_3 = px[3];
  assign w0.data_i_4 = px[4]; assign w1.data_i_4 = px[4]; assign w2.data_i_4 = px[4];
  assign w0.data_i_5 = px[5]; assign w1.data_i_5 = px[5]; assign w2.data_i_5 = px[5];
  assign w0.data_i_6 = px[6]; assign w1.data_i_6 = px[6]; assign w2.data_i_6 = px[6];
  assign w0.data_i_7 = px[7]; assign w1.data_i_7 = px[7]; assign w2.data_i_7 = px[7];
  assign w0.data_i_8 = px[8]; assign w1.data_i_8 = px[8]; assign w2.data_i_8 = px[8];

  sharpen_core #(.KERNEL_SEL(0), .CNT_W(17)) u_k0 (.clk_i(clk), .rst_i(rst), .win(w0));
  sharpen_core #(.KERNEL_SEL(1), .CNT_W(17)) u_k1 (.clk_i(clk), .rst_i(rst), .win(w1));
  sharpen_core #(.KERNEL_SEL(0), .CNT_W(2))  u_nc (.clk_i(clk), .rst_i(rst), .win(w2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_win(input logic [7:0] c, input logic [7:0] e, input logic [7:0] k);
    px[0] = k; px[2] = k; px[6] = k; px[8] = k;
    px[1] = e; px[3] = e; px[5] = e; px[7] = e;
    px[4] = c;
  endtask

  task automatic scramble();
    for (int i = 0; i < 9; i++) px[i] = 8'($urandom_range(0, 255));
  endtask

  // Reference: spec formula on the captured pixels, then clamp.
  function automatic void model(input int ks, input logic [7:0] p [9],
                                output logic [7:0] d, output logic s);
    int sum;
    if (ks == 0) begin
      sum = 5 * int'(p[4]) - int'(p[1]) - int'(p[3]) - int'(p[5]) - int'(p[7]);
    end else begin
      sum = 9 * int'(p[4]);
      for (int i = 0; i < 9; i++) if (i != 4) sum = sum - int'(p[i]);
    end
    if (sum < 0) begin d = 8'd0; s = 1'b1; end
    else if (sum > 255) begin d = 8'd255; s = 1'b1; end
    else begin d = 8'(sum); s = 1'b0; end
  endfunction

  task automatic window(input string tag, input logic [7:0] c, input logic [7:0] e,
                        input logic [7:0] k, input logic [7:0] d0, input logic s0,
                        input logic [7:0] d1, input logic s1);
    set_win(c, e, k);
    en = 1'b1;
    @(posedge clk); #1;
    scramble();
    chk({tag, "_add_done"}, 32'(w0.sonuc_done), 0);
    @(posedge clk); #1;
    chk({tag, "_clamp_done"}, 32'(w0.sonuc_done), 0);
    @(posedge clk); #1;
    exp_cnt++;
    chk({tag, "_done_k0"}, 32'(w0.sonuc_done), 1);
    chk({tag, "_data_k0"}, 32'(w0.data_o), 32'(d0));
    chk({tag, "_sat_k0"}, 32'(w0.sat_o), 32'(s0));
    chk({tag, "_done_k1"}, 32'(w1.sonuc_done), 1);
    chk({tag, "_data_k1"}, 32'(w1.data_o), 32'(d1));
    chk({tag, "_sat_k1"}, 32'(w1.sat_o), 32'(s1));
    chk({tag, "_cnt"}, 32'(w0.done_cnt_o), 32'(exp_cnt));
    chk({tag, "_cnt_narrow"}, 32'(w2.done_cnt_o), 32'(exp_cnt % 4));
    @(posedge clk); #1;
    chk({tag, "_hold_done"}, 32'(w0.sonuc_done), 1);
    chk({tag, "_hold_cnt"}, 32'(w1.done_cnt_o), 32'(exp_cnt));
    en = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_drop_done"}, 32'(w0.sonuc_done), 0);
    chk({tag, "_drop_sat"}, 32'(w1.sat_o), 0);
    chk({tag, "_drop_data"}, 32'(w0.data_o), 32'(d0));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] cap [9];
    logic [7:0] md0, md1;
    logic       ms0, ms1;
    int         lat;
    int         base;

    set_win(8'd0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(w0.sonuc_done), 0);
    chk("rst_data", 32'(w0.data_o), 0);
    chk("rst_sat", 32'(w1.sat_o), 0);
    chk("rst_cnt", 32'(w1.done_cnt_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    window("flat",    8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 8'd100, 1'b0);
    window("hi",      8'd200, 8'd0,   8'd0,   8'd255, 1'b1, 8'd255, 1'b1);
    window("lo",      8'd0,   8'd255, 8'd255, 8'd0,   1'b1, 8'd0,   1'b1);
    window("mid",     8'd50,  8'd40,  8'd40,  8'd90,  1'b0, 8'd130, 1'b0);
    window("c255",    8'd255, 8'd0,   8'd0,   8'd255, 1'b1, 8'd255, 1'b1);
    window("edge255", 8'd51,  8'd0,   8'd0,   8'd255, 1'b0, 8'd255, 1'b1);
    window("corners", 8'd100, 8'd0,   8'd255, 8'd255, 1'b1, 8'd0,   1'b1);
    window("zero",    8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   1'b0);
    window("mixed",   8'd30,  8'd25,  8'd0,   8'd50,  1'b0, 8'd170, 1'b0);

    // Abort in ADD: enable held for the capture edge only.
    set_win(8'd77, 8'd1, 8'd2);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_add_done", 32'(w0.sonuc_done), 0);
    end
    chk("abort_add_cnt", 32'(w0.done_cnt_o), 32'(exp_cnt));

    // Abort in CLAMP.
    en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_clamp_done", 32'(w1.sonuc_done), 0);
    end
    chk("abort_clamp_cnt", 32'(w1.done_cnt_o), 32'(exp_cnt));

    window("after_abort", 8'd10, 8'd10, 8'd10, 8'd10, 1'b0, 8'd10, 1'b0);

    // One image row back to back: en dropped for exactly one edge after each done.
    base = exp_cnt;
    for (int w = 0; w < 318; w++) begin
      scramble();
      cap = px;
      en = 1'b1;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
        if (lat == 1) scramble();
      end while (!w0.sonuc_done && lat < 8);
      exp_cnt++;
      model(0, cap, md0, ms0);
      model(1, cap, md1, ms1);
      chk("row_latency", 32'(lat), 3);
      chk("row_data_k0", 32'(w0.data_o), 32'(md0));
      chk("row_sat_k0", 32'(w0.sat_o), 32'(ms0));
      chk("row_data_k1", 32'(w1.data_o), 32'(md1));
      chk("row_sat_k1", 32'(w1.sat_o), 32'(ms1));
      en = 1'b0;
      @(posedge clk); #1;
    end
    chk("row_cnt", 32'(w0.done_cnt_o - 17'(base)), 318);
    chk("row_cnt_narrow", 32'(w2.done_cnt_o), 32'(exp_cnt % 4));

    // Asynchronous reset while holding a result in DONE.
    set_win(8'd200, 8'd0, 8'd0);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_done", 32'(w0.sonuc_done), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_done", 32'(w0.sonuc_done), 0);
    chk("async_rst_data", 32'(w0.data_o), 0);
    chk("async_rst_cnt", 32'(w0.done_cnt_o), 0);
    chk("async_rst_sat", 32'(w1.sat_o), 0);
    en = 1'b0;
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;
    window("post_rst", 8'd50, 8'd40, 8'd40, 8'd90, 1'b0, 8'd130, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
